// File: rtl/cu_pkg.sv
//------------------------------------------------------------------------------
// Module : cu_pkg
// Brief  : Opcodes, instruction field positions and FSM/decode types for the
//          control-unit sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cu_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'b1010;
  localparam logic [3:0] OP_MOV     = 4'b1011;
  localparam logic [3:0] OP_LDI     = 4'b1100;
  localparam logic [3:0] OP_RDR     = 4'b1101;
  localparam logic [3:0] OP_JMP     = 4'b1110;
  localparam logic [3:0] OP_HLT     = 4'b1111;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 9;
  localparam int RB_MSB  = 8;
  localparam int RB_LSB  = 6;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HALT   = 3'd4
  } cu_state_e;

  typedef enum logic [2:0] {
    CL_ALU = 3'd0,
    CL_MOV = 3'd1,
    CL_LDI = 3'd2,
    CL_RDR = 3'd3,
    CL_JMP = 3'd4,
    CL_HLT = 3'd5
  } cu_class_e;

  // upd_* mark which EU buses an instruction overwrites; the rest hold.
  typedef struct packed {
    cu_class_e  cls;
    logic [3:0] opcode;
    logic       rd;
    logic       wr;
    logic       upd_ade;
    logic       upd_mov;
    logic       upd_idt;
    logic [2:0] ade;
    logic [2:0] ad_mov;
    logic [7:0] imm;
    logic       jmp_cond;
    logic       jmp_sel;
  } cu_dec_t;

endpackage

`default_nettype wire

// File: rtl/cu_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : cu_sequencer_if
// Brief  : Program-memory fetch handshake, EU control bus and status of the
//          control-unit sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [1:0]      flag;
  logic [3:0]      opcode;
  logic            rd;
  logic            wr;
  logic [2:0]      ade_bus;
  logic [2:0]      ad_mov;
  logic [7:0]      idt_bus;
  logic [PC_W-1:0] pc;
  logic            halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data, flag,
    output opcode, rd, wr, ade_bus, ad_mov, idt_bus, pc, halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data, flag,
    input  opcode, rd, wr, ade_bus, ad_mov, idt_bus, pc, halted
  );
endinterface

`default_nettype wire

// File: rtl/cu_decode.sv
//------------------------------------------------------------------------------
// Module : cu_decode
// Brief  : Combinational instruction decoder: IR to EU controls, instruction
//          class and jump condition.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cu_decode
  import cu_pkg::*;
(
  input  logic [15:0] i_ir,
  output cu_dec_t     o_dec
);

  logic [3:0] w_op;

  assign w_op = i_ir[OP_MSB:OP_LSB];

  always_comb begin
    o_dec          = '0;
    o_dec.opcode   = w_op;
    o_dec.ade      = i_ir[RA_MSB:RA_LSB];
    o_dec.ad_mov   = i_ir[RB_MSB:RB_LSB];
    o_dec.imm      = i_ir[IMM_MSB:IMM_LSB];
    // ra[0] enables the condition, ra[1] picks zero or carry
    o_dec.jmp_cond = i_ir[RA_LSB];
    o_dec.jmp_sel  = i_ir[RA_LSB+1];
    if (w_op <= OP_ALU_MAX) begin
      o_dec.cls = CL_ALU;
    end else begin
      case (w_op)
        OP_MOV: begin
          o_dec.cls     = CL_MOV;
          o_dec.upd_ade = 1'b1;
          o_dec.upd_mov = 1'b1;
        end
        OP_LDI: begin
          o_dec.cls     = CL_LDI;
          o_dec.wr      = 1'b1;
          o_dec.upd_ade = 1'b1;
          o_dec.upd_idt = 1'b1;
        end
        OP_RDR: begin
          o_dec.cls     = CL_RDR;
          o_dec.rd      = 1'b1;
          o_dec.upd_ade = 1'b1;
        end
        OP_JMP:  o_dec.cls = CL_JMP;
        default: o_dec.cls = CL_HLT;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/cu_sequencer.sv
//------------------------------------------------------------------------------
// Module : cu_sequencer
// Brief  : Fetch/decode/execute sequencer driving the EU control bus for one
//          clock per instruction, with conditional jumps and halt.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cu_sequencer
  import cu_pkg::*;
#(
  parameter int              PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk_cu,
  input  logic            rst_cu,
  cu_sequencer_if.master  bus
);

  cu_state_e       r_state;
  logic [15:0]     r_ir;
  logic [PC_W-1:0] r_pc;
  logic            r_imem_req;
  logic            r_rd;
  logic            r_wr;
  logic            r_halted;
  logic [3:0]      r_opcode;
  logic [3:0]      r_last_alu;
  logic [2:0]      r_ade;
  logic [2:0]      r_ad_mov;
  logic [7:0]      r_idt;

  cu_dec_t         w_dec;
  logic            w_jmp_taken;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_jmp_target;

  cu_decode u_decode (
    .i_ir  (r_ir),
    .o_dec (w_dec)
  );

  assign w_pc_inc     = r_pc + PC_W'(1);
  assign w_jmp_target = PC_W'(w_dec.imm);
  assign w_jmp_taken  = !w_dec.jmp_cond || bus.flag[w_dec.jmp_sel];

  always_ff @(posedge clk_cu or posedge rst_cu) begin
    if (rst_cu) begin
      r_state    <= ST_FETCH;
      r_ir       <= '0;
      r_pc       <= RST_PC;
      r_imem_req <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_halted   <= 1'b0;
      r_opcode   <= '0;
      r_last_alu <= '0;
      r_ade      <= '0;
      r_ad_mov   <= '0;
      r_idt      <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          // req is low only on the first cycle out of reset
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
          end else if (bus.imem_ack) begin
            r_ir       <= bus.imem_data;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (w_dec.cls)
            CL_HLT: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
            CL_JMP: begin
              r_pc       <= w_jmp_taken ? w_jmp_target : w_pc_inc;
              r_imem_req <= 1'b1;
              r_state    <= ST_FETCH;
            end
            default: begin
              r_opcode <= w_dec.opcode;
              r_rd     <= w_dec.rd;
              r_wr     <= w_dec.wr;
              if (w_dec.upd_ade) r_ade    <= w_dec.ade;
              if (w_dec.upd_mov) r_ad_mov <= w_dec.ad_mov;
              if (w_dec.upd_idt) r_idt    <= w_dec.imm;
              if (w_dec.cls == CL_ALU) r_last_alu <= w_dec.opcode;
              r_state  <= ST_EXEC;
            end
          endcase
        end
        ST_EXEC: begin
          r_rd     <= 1'b0;
          r_wr     <= 1'b0;
          r_opcode <= r_last_alu;
          r_pc     <= w_pc_inc;
          if (w_dec.cls == CL_ALU) begin
            r_state <= ST_SETTLE;
          end else begin
            r_imem_req <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_SETTLE: begin
          r_imem_req <= 1'b1;
          r_state    <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign bus.imem_req  = r_imem_req;
  assign bus.imem_addr = r_pc;
  assign bus.opcode    = r_opcode;
  assign bus.rd        = r_rd;
  assign bus.wr        = r_wr;
  assign bus.ade_bus   = r_ade;
  assign bus.ad_mov    = r_ad_mov;
  assign bus.idt_bus   = r_idt;
  assign bus.pc        = r_pc;
  assign bus.halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_cu_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_cu_sequencer
// Brief  : Directed self-checking bench for cu_sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cu_sequencer;
  import cu_pkg::*;

  logic clk_cu = 1'b0;
  logic rst_cu = 1'b1;

  cu_sequencer_if #(.PC_W(8)) bus ();

  cu_sequencer #(.PC_W(8), .RST_PC(8'h00)) dut (
    .clk_cu (clk_cu),
    .rst_cu (rst_cu),
    .bus    (bus)
  );

  always #5 clk_cu = ~clk_cu;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem [256];
  int          ack_delay = 0;
  logic        man_mode  = 1'b0;
  int          wait_cnt  = 0;

  // Program memory: ack after ack_delay waiting cycles, or free-running pulses in manual mode
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0000;
    forever begin
      @(negedge clk_cu);
      if (man_mode) begin
        bus.imem_ack  = ~bus.imem_ack;
        bus.imem_data = 16'hC1FF;
      end else if (bus.imem_req === 1'b1) begin
        if (wait_cnt < ack_delay) begin
          bus.imem_ack = 1'b0;
          wait_cnt++;
        end else begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem[bus.imem_addr];
          wait_cnt      = 0;
        end
      end else begin
        bus.imem_ack = 1'b0;
        wait_cnt     = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic apply_reset();
    @(negedge clk_cu);
    rst_cu = 1'b1;
    @(negedge clk_cu);
    @(negedge clk_cu);
    rst_cu = 1'b0;
  endtask

  task automatic test_reset();
    rst_cu = 1'b1;
    repeat (3) @(negedge clk_cu);
    n_tests++;
    if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    n_tests++;
    if (bus.rd !== 1'b0 || bus.wr !== 1'b0) begin n_fail++; $display("FAIL reset_rdwr: got %b%b expected 00", bus.rd, bus.wr); end
    n_tests++;
    if (bus.opcode !== 4'h0) begin n_fail++; $display("FAIL reset_opcode: got %h expected 0", bus.opcode); end
    n_tests++;
    if ({bus.ade_bus, bus.ad_mov, bus.idt_bus} !== 14'h0) begin
      n_fail++; $display("FAIL reset_buses: got %h/%h/%h expected 0/0/00", bus.ade_bus, bus.ad_mov, bus.idt_bus);
    end
    n_tests++;
    if (bus.halted !== 1'b0 || bus.pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc_halt: got pc %h halted %b expected 00 0", bus.pc, bus.halted); end
    rst_cu = 1'b0;
    @(negedge clk_cu);
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_first_req: got req %b addr %h expected 1 00", bus.imem_req, bus.imem_addr);
    end
  endtask

  // LDI r0,05; LDI r1,03; ALU add; HLT with every fetch acked after d waiting cycles
  task automatic run_basic(input int d);
    int e1, e2, ea, eh;
    logic exp_wr;
    logic [3:0] exp_op;
    clear_mem();
    mem[0] = 16'hC005;
    mem[1] = 16'hC203;
    mem[2] = 16'h0000;
    mem[3] = 16'hF000;
    ack_delay = d;
    bus.flag  = 2'b00;
    apply_reset();
    e1 = 3 + d;
    e2 = 6 + 2*d;
    ea = 9 + 3*d;
    eh = 13 + 4*d;
    for (int c = 1; c <= eh; c++) begin
      @(negedge clk_cu);
      exp_wr = (c == e1) || (c == e2);
      exp_op = exp_wr ? 4'hC : 4'h0;
      n_tests++;
      if (bus.wr !== exp_wr || bus.rd !== 1'b0 || bus.opcode !== exp_op) begin
        n_fail++;
        $display("FAIL basic_ctrl d=%0d c=%0d: got wr %b rd %b op %h expected wr %b rd 0 op %h", d, c, bus.wr, bus.rd, bus.opcode, exp_wr, exp_op);
      end
      if (c <= 1 + d) begin
        n_tests++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
          n_fail++; $display("FAIL basic_fetch0 d=%0d c=%0d: got req %b addr %h expected 1 00", d, c, bus.imem_req, bus.imem_addr);
        end
      end
      if (c == e1) begin
        n_tests++;
        if (bus.ade_bus !== 3'd0 || bus.idt_bus !== 8'h05) begin
          n_fail++; $display("FAIL basic_ldi0 d=%0d: got ade %0d idt %h expected 0 05", d, bus.ade_bus, bus.idt_bus);
        end
      end
      if (c == e2) begin
        n_tests++;
        if (bus.ade_bus !== 3'd1 || bus.idt_bus !== 8'h03) begin
          n_fail++; $display("FAIL basic_ldi1 d=%0d: got ade %0d idt %h expected 1 03", d, bus.ade_bus, bus.idt_bus);
        end
      end
      n_tests++;
      if (bus.halted !== (c >= eh)) begin
        n_fail++; $display("FAIL basic_halted d=%0d c=%0d: got %b expected %b", d, c, bus.halted, (c >= eh));
      end
    end
    n_tests++;
    if (bus.pc !== 8'h03) begin n_fail++; $display("FAIL basic_pc d=%0d: got %h expected 03", d, bus.pc); end
    ack_delay = 0;
  endtask

  task automatic test_basic();
    run_basic(0);
  endtask

  task automatic test_ack_delay();
    run_basic(3);
  endtask

  task automatic test_jmp();
    logic [15:0] ins [6];
    logic [1:0]  flg [6];
    logic [7:0]  tgt [6];
    ins = '{16'hE220, 16'hE220, 16'hE020, 16'hE020, 16'hE620, 16'hE620};
    flg = '{2'b01,    2'b00,    2'b00,    2'b11,    2'b10,    2'b01};
    tgt = '{8'h20,    8'h01,    8'h20,    8'h20,    8'h20,    8'h01};
    for (int k = 0; k < 6; k++) begin
      clear_mem();
      mem[0]   = ins[k];
      bus.flag = flg[k];
      apply_reset();
      repeat (2) @(negedge clk_cu);
      n_tests++;
      if (bus.rd !== 1'b0 || bus.wr !== 1'b0 || bus.opcode !== 4'h0) begin
        n_fail++; $display("FAIL jmp_idle k=%0d: got rd %b wr %b op %h expected 0 0 0", k, bus.rd, bus.wr, bus.opcode);
      end
      @(negedge clk_cu);
      n_tests++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== tgt[k]) begin
        n_fail++; $display("FAIL jmp_target k=%0d: got req %b addr %h expected 1 %h", k, bus.imem_req, bus.imem_addr, tgt[k]);
      end
    end
    bus.flag = 2'b00;
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0]    = 16'hE0FF;
    mem[8'hFF] = 16'hB500;
    apply_reset();
    repeat (3) @(negedge clk_cu);
    n_tests++;
    if (bus.imem_addr !== 8'hFF) begin n_fail++; $display("FAIL wrap_fetch_ff: got %h expected ff", bus.imem_addr); end
    @(negedge clk_cu);
    n_tests++;
    if (bus.opcode !== 4'h0) begin n_fail++; $display("FAIL wrap_pre_exec: got op %h expected 0", bus.opcode); end
    @(negedge clk_cu);
    n_tests++;
    if (bus.opcode !== 4'hB || bus.ade_bus !== 3'd2 || bus.ad_mov !== 3'd4 || bus.wr !== 1'b0 || bus.rd !== 1'b0) begin
      n_fail++; $display("FAIL wrap_mov_exec: got op %h ade %0d mov %0d rd %b wr %b expected b 2 4 0 0", bus.opcode, bus.ade_bus, bus.ad_mov, bus.rd, bus.wr);
    end
    @(negedge clk_cu);
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00 || bus.opcode !== 4'h0) begin
      n_fail++; $display("FAIL wrap_next: got req %b addr %h op %h expected 1 00 0", bus.imem_req, bus.imem_addr, bus.opcode);
    end
  endtask

  // ALU 0101 then RDR r3: opcode returns to the last ALU op after RDR's EXEC
  task automatic test_rdr_hold();
    clear_mem();
    mem[0] = 16'h5000;
    mem[1] = 16'hD600;
    apply_reset();
    repeat (3) @(negedge clk_cu);
    n_tests++;
    if (bus.opcode !== 4'h5 || bus.rd !== 1'b0 || bus.wr !== 1'b0) begin
      n_fail++; $display("FAIL rdr_alu_exec: got op %h rd %b wr %b expected 5 0 0", bus.opcode, bus.rd, bus.wr);
    end
    @(negedge clk_cu);
    n_tests++;
    if (bus.opcode !== 4'h5 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rdr_settle: got op %h req %b expected 5 0", bus.opcode, bus.imem_req);
    end
    repeat (3) @(negedge clk_cu);
    n_tests++;
    if (bus.opcode !== 4'hD || bus.rd !== 1'b1 || bus.wr !== 1'b0 || bus.ade_bus !== 3'd3) begin
      n_fail++; $display("FAIL rdr_exec: got op %h rd %b wr %b ade %0d expected d 1 0 3", bus.opcode, bus.rd, bus.wr, bus.ade_bus);
    end
    @(negedge clk_cu);
    n_tests++;
    if (bus.opcode !== 4'h5 || bus.rd !== 1'b0 || bus.imem_addr !== 8'h02) begin
      n_fail++; $display("FAIL rdr_after: got op %h rd %b addr %h expected 5 0 02", bus.opcode, bus.rd, bus.imem_addr);
    end
  endtask

  task automatic test_reset_exec();
    clear_mem();
    mem[0]     = 16'hE040;
    mem[8'h40] = 16'hCAAA;
    apply_reset();
    repeat (5) @(negedge clk_cu);
    n_tests++;
    if (bus.wr !== 1'b1 || bus.pc !== 8'h40 || bus.ade_bus !== 3'd5) begin
      n_fail++; $display("FAIL rstx_pre: got wr %b pc %h ade %0d expected 1 40 5", bus.wr, bus.pc, bus.ade_bus);
    end
    #2 rst_cu = 1'b1;
    #1;
    n_tests++;
    if (bus.wr !== 1'b0 || bus.pc !== 8'h00 || bus.halted !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstx_async: got wr %b pc %h halted %b req %b expected 0 00 0 0", bus.wr, bus.pc, bus.halted, bus.imem_req);
    end
    n_tests++;
    if (dut.r_state !== ST_FETCH) begin n_fail++; $display("FAIL rstx_state: got %0d expected %0d", dut.r_state, ST_FETCH); end
    @(posedge clk_cu);
    #1;
    n_tests++;
    if (bus.wr !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL rstx_held: got wr %b req %b expected 0 0", bus.wr, bus.imem_req);
    end
    @(negedge clk_cu);
    rst_cu = 1'b0;
    @(negedge clk_cu);
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      n_fail++; $display("FAIL rstx_restart: got req %b addr %h expected 1 00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_halt();
    clear_mem();
    mem[0] = 16'hC011;
    mem[1] = 16'hF000;
    apply_reset();
    repeat (6) @(negedge clk_cu);
    n_tests++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_enter: got %b expected 1", bus.halted); end
    man_mode = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_cu);
      n_tests++;
      if (bus.imem_req !== 1'b0 || bus.halted !== 1'b1 || bus.pc !== 8'h01 || bus.rd !== 1'b0 ||
          bus.wr !== 1'b0 || bus.idt_bus !== 8'h11 || bus.opcode !== 4'h0) begin
        n_fail++;
        $display("FAIL halt_hold c=%0d: got req %b halted %b pc %h rd %b wr %b idt %h op %h expected 0 1 01 0 0 11 0",
                 c, bus.imem_req, bus.halted, bus.pc, bus.rd, bus.wr, bus.idt_bus, bus.opcode);
      end
    end
    man_mode = 1'b0;
    #2 rst_cu = 1'b1;
    #1;
    n_tests++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got %b expected 0", bus.halted); end
    @(negedge clk_cu);
    rst_cu = 1'b0;
  endtask

  initial begin
    bus.flag = 2'b00;
    clear_mem();
    test_reset();
    test_basic();
    test_ack_delay();
    test_jmp();
    test_wrap();
    test_rdr_hold();
    test_reset_exec();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cu_sequencer.md
# cu_sequencer

Control-unit sequencer sitting directly upstream of the execution unit. Fetches 16-bit instructions from program memory over a req/ack handshake, decodes them, and drives the EU control bus (`opcode`, `rd`, `wr`, `ade_bus`, `ad_mov`, `idt_bus`) for exactly one EU clock per instruction. Uses the EU `flag` output for conditional jumps and stops on HLT.

## Interface
- `PC_W`, default 8: program counter / instruction address width.
- `RST_PC`, default 0: PC value loaded on reset.
- `clk_cu`  in  1  sole clock; the EU shares it as `clk_eu`.
- `rst_cu`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; held high until ack.
- `imem_addr`  out  PC_W  fetch address, equal to the PC while `imem_req` is high.
- `imem_ack`  in  1  `imem_data` is valid this cycle.
- `imem_data`  in  16  instruction word.
- `flag`  in  2  EU flags; [0] zero, [1] carry.
- `opcode`  out  4  EU opcode.
- `rd`  out  1  EU register read strobe.
- `wr`  out  1  EU register write strobe.
- `ade_bus`  out  3  EU destination/read register address.
- `ad_mov`  out  3  EU MOV source register address.
- `idt_bus`  out  8  EU write data.
- `pc`  out  PC_W  current PC.
- `halted`  out  1  high while in HALT.

## Operation
- Instruction format: [15:12] op, [11:9] ra, [8:6] rb, [7:0] imm8. imm8 overlaps rb.
- Opcode classes:
  - 0000–1010 ALU: EU operates on r0, r1 (rd=0, wr=0).
  - 1011 MOV: r[ra] ← r[rb].
  - 1100 LDI: r[ra] ← imm8 (wr=1).
  - 1101 RDR: present r[ra] on the EU result (rd=1).
  - 1110 JMP: if ra[0]=0, unconditional. If ra[0]=1, taken only when `flag[ra[1]]`=1. Target is PC ← imm8.
  - 1111 HLT.
- FSM states: FETCH, DECODE, EXEC, SETTLE, HALT.
- FETCH:
  - `imem_req`=1 and `imem_addr`=pc.
  - On `imem_ack`: latch IR, go to DECODE. Without ack, stay in FETCH with no timeout.
- DECODE: register the decoded controls, then go to EXEC.
  - HLT goes to HALT instead.
  - JMP resolves here using the current `flag`: PC ← imm8 if taken, else PC+1. Then go to FETCH; JMP never enters EXEC.
- EXEC: drive the decoded controls for one cycle, PC ← PC+1.
  - ALU ops go to SETTLE.
  - All other ops go to FETCH.
- SETTLE: one idle cycle so that `flag` and `result` reflect the ALU op before any following JMP decodes. Then go to FETCH.
- Idle drive (every state except EXEC):
  - `rd`=0, `wr`=0.
  - `opcode` holds the last ALU opcode issued (reset 0000), so the EU re-latching its ALU path is idempotent.
  - `ade_bus`, `ad_mov`, `idt_bus` hold their previous values.
- PC arithmetic is modulo 2^PC_W; from all-ones it wraps to 0.
- HALT: outputs idle and `halted`=1. Leave HALT only by reset.

## Timing
- Reset values (async): state FETCH, pc=RST_PC, `imem_req`=0 during reset, `rd`=`wr`=0, `opcode`=0000, buses 0, `halted`=0.
- After reset release, `imem_req` rises in the first clock edge's cycle.
- Cycles per instruction, with ack in the same cycle as req:
  - ALU: 4.
  - MOV, LDI, RDR: 3.
  - JMP: 2.
- Each extra cycle before `imem_ack` adds one cycle.
- `imem_data` is sampled only when `imem_ack`=1; `imem_ack` outside FETCH is ignored.
- EU controls are registered outputs. The EU acts on the edge that ends EXEC.
- Reset asserted mid-instruction aborts it immediately. No partial EU write can occur after reset asserts.

## Structure
- `cu_pkg`: opcode localparams (OP_MOV=4'b1011, OP_LDI, OP_RDR, OP_JMP, OP_HLT, ALU range bound), FSM state enum, instruction field positions.
- One combinational sub-module `cu_decode`: IR in → decoded controls, class (alu/mov/ldi/rdr/jmp/hlt) and jump condition out.
- The FSM and PC live in `cu_sequencer`.

## Test plan
- Reset, then program `LDI r0,8'h05`; `LDI r1,8'h03`; ALU add (0000); HLT, ack immediate → writes go to r0 and r1 via `wr`=1 with `idt_bus` 05 then 03. ALU EXEC has `opcode`=0000, `rd`=`wr`=0. `halted`=1 after 12 cycles. pc=3.
- `imem_ack` delayed 3 cycles on every fetch → the same sequence completes in 12+12 cycles. Controls stay idle while waiting.
- Conditional JMP with ra=001 to imm8=8'h20, tested with `flag`[0]=1 and with `flag`[0]=0 → next `imem_addr` is 20 when the flag is set, pc+1 when clear. Unconditional JMP with ra=000 → 20 regardless of flags.
- PC at 8'hFF executing MOV r2,r4 → one EXEC cycle with `opcode`=1011, `ade_bus`=2, `ad_mov`=4. Next fetch address is 8'h00.
- `rst_cu` pulsed during EXEC of an LDI → `wr` drops asynchronously, pc=RST_PC, state FETCH, `halted`=0.
- HLT followed by `imem_ack` pulses → no further `imem_req`, outputs remain idle until reset.
